// File: rtl/exu_alu_pipe.sv
// Pipelined integer ALU with in-stage branch resolution, self-kill of the
// following issue on mispredict and a saturating mispredict counter.
module exu_alu_pipe #(
  parameter int XLEN = 64,
  parameter int PIPE = 2,
  parameter int TAGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            freeze,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [3:0]      in_op,
  input  logic            in_word,
  input  logic [2:0]      in_br,
  input  logic            in_rvc,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [30:0]     in_pc,
  input  logic [11:0]     in_brimm,
  input  logic            in_pred_t,
  input  logic [30:0]     in_pred_tgt,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            flush_upper,
  output logic [30:0]     flush_path,
  output logic [CNTW-1:0] misp_cnt
);

  localparam int SHW = $clog2(XLEN);
  localparam bit WORD_OK = (XLEN == 64);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MIN, OP_MAX, OP_MINU, OP_MAXU, OP_PASSB, OP_LINK
  } op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL
  } br_e;

  typedef struct packed {
    op_e             op;
    logic            word;
    br_e             br;
    logic            rvc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [30:0]     pc;
    logic [11:0]     brimm;
    logic            pred_t;
    logic [30:0]     pred_tgt;
    logic [TAGW-1:0] tag;
  } e1_t;

  e1_t             e1_q, e1_d;
  logic            e1_valid_q, e1_valid_d;
  logic [30:0]     flush_path_q, flush_path_d;
  logic [CNTW-1:0] misp_cnt_q, misp_cnt_d;

  logic            word_m, lt_s, lt_u, gt_s, gt_u, taken, misp;
  logic [XLEN-1:0] opa, opb, srl_src, raw, alu_res;
  logic [SHW-1:0]  shamt;
  logic [30:0]     fall, target;

  // Issue capture; an external flush beats freeze for the stage valid.
  always_comb begin
    e1_d = e1_q;
    if (in_valid && !freeze) begin
      e1_d.op       = op_e'(in_op);
      e1_d.word     = in_word;
      e1_d.br       = br_e'(in_br);
      e1_d.rvc      = in_rvc;
      e1_d.a        = in_a;
      e1_d.b        = in_b;
      e1_d.pc       = in_pc;
      e1_d.brimm    = in_brimm;
      e1_d.pred_t   = in_pred_t;
      e1_d.pred_tgt = in_pred_tgt;
      e1_d.tag      = in_tag;
    end
    e1_valid_d = e1_valid_q;
    if (flush) begin
      e1_valid_d = 1'b0;
    end else if (!freeze) begin
      e1_valid_d = in_valid & ~flush_upper;
    end
  end

  // Word ops compare sign-extended low halves, which orders both signed and unsigned correctly.
  always_comb begin
    word_m  = WORD_OK && e1_q.word;
    opa     = word_m ? XLEN'($signed(e1_q.a[31:0])) : e1_q.a;
    opb     = word_m ? XLEN'($signed(e1_q.b[31:0])) : e1_q.b;
    srl_src = word_m ? XLEN'(e1_q.a[31:0]) : e1_q.a;
    shamt   = word_m ? SHW'(e1_q.b[4:0]) : e1_q.b[SHW-1:0];
    lt_s    = $signed(opa) < $signed(opb);
    gt_s    = $signed(opb) < $signed(opa);
    lt_u    = opa < opb;
    gt_u    = opb < opa;
    fall    = e1_q.pc + (e1_q.rvc ? 31'd1 : 31'd2);
    case (e1_q.op)
      OP_ADD:   raw = opa + opb;
      OP_SUB:   raw = opa - opb;
      OP_AND:   raw = opa & opb;
      OP_OR:    raw = opa | opb;
      OP_XOR:   raw = opa ^ opb;
      OP_SLL:   raw = opa << shamt;
      OP_SRL:   raw = srl_src >> shamt;
      OP_SRA:   raw = $signed(opa) >>> shamt;
      OP_SLT:   raw = XLEN'(lt_s);
      OP_SLTU:  raw = XLEN'(lt_u);
      OP_MIN:   raw = gt_s ? opb : opa;
      OP_MAX:   raw = lt_s ? opb : opa;
      OP_MINU:  raw = gt_u ? opb : opa;
      OP_MAXU:  raw = lt_u ? opb : opa;
      OP_PASSB: raw = opb;
      OP_LINK:  raw = XLEN'({fall, 1'b0});
      default:  raw = '0;
    endcase
    alu_res = word_m ? XLEN'($signed(raw[31:0])) : raw;
  end

  // JAL target is (A+B)[31:1]; bit-0 carry folded in so no sum bit is left unused.
  always_comb begin
    case (e1_q.br)
      BR_BEQ:  taken = (opa == opb);
      BR_BNE:  taken = (opa != opb);
      BR_BLT:  taken = lt_s;
      BR_BGE:  taken = ~lt_s;
      BR_BLTU: taken = lt_u;
      BR_BGEU: taken = ~lt_u;
      BR_JAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (e1_q.br == BR_JAL) begin
      target = e1_q.a[31:1] + e1_q.b[31:1] + 31'(e1_q.a[0] & e1_q.b[0]);
    end else begin
      target = e1_q.pc + 31'($signed(e1_q.brimm));
    end
    misp = e1_valid_q && (e1_q.br != BR_NONE) &&
           ((taken != e1_q.pred_t) || ((e1_q.br == BR_JAL) && (e1_q.pred_tgt != target)));
    flush_upper  = misp & ~flush & ~freeze;
    flush_path_d = flush_upper ? (taken ? target : fall) : flush_path_q;
    misp_cnt_d   = misp_cnt_q;
    if (flush_upper && (misp_cnt_q != {CNTW{1'b1}})) begin
      misp_cnt_d = misp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      e1_q         <= '0;
      e1_valid_q   <= 1'b0;
      flush_path_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      e1_q         <= e1_d;
      e1_valid_q   <= e1_valid_d;
      flush_path_q <= flush_path_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign flush_path = flush_path_d;
  assign misp_cnt   = misp_cnt_q;

  if (PIPE == 1) begin : g_pipe1
    assign out_valid  = e1_valid_q;
    assign out_result = alu_res;
    assign out_tag    = e1_q.tag;
  end else begin : g_pipe2
    logic            e2_valid_q, e2_valid_d;
    logic [XLEN-1:0] e2_result_q, e2_result_d;
    logic [TAGW-1:0] e2_tag_q, e2_tag_d;

    // Result register only reloads on a live op so outputs hold their last value.
    always_comb begin
      e2_result_d = e2_result_q;
      e2_tag_d    = e2_tag_q;
      e2_valid_d  = e2_valid_q;
      if (!freeze && e1_valid_q) begin
        e2_result_d = alu_res;
        e2_tag_d    = e1_q.tag;
      end
      if (flush) begin
        e2_valid_d = 1'b0;
      end else if (!freeze) begin
        e2_valid_d = e1_valid_q;
      end
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        e2_valid_q  <= 1'b0;
        e2_result_q <= '0;
        e2_tag_q    <= '0;
      end else begin
        e2_valid_q  <= e2_valid_d;
        e2_result_q <= e2_result_d;
        e2_tag_q    <= e2_tag_d;
      end
    end

    assign out_valid  = e2_valid_q;
    assign out_result = e2_result_q;
    assign out_tag    = e2_tag_q;
  end

endmodule

// File: tb/tb_exu_alu_pipe.sv
// Bench for exu_alu_pipe (XLEN=64, PIPE=2, CNTW=2): ALU vector table through a
// result scoreboard plus hand sequences for mispredict, freeze/flush and reset.
module tb_exu_alu_pipe;
  localparam int TAGW = 5;
  localparam int CNTW = 2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_OR = 4'd3, OP_XOR = 4'd4,
    OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9,
    OP_MIN = 4'd10, OP_MAX = 4'd11, OP_MINU = 4'd12, OP_MAXU = 4'd13,
    OP_PASSB = 4'd14, OP_LINK = 4'd15;
  localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_JAL = 3'd7;

  logic            clk = 1'b0;
  logic            rst_l, freeze, flush, in_valid, in_word, in_rvc, in_pred_t;
  logic [3:0]      in_op;
  logic [2:0]      in_br;
  logic [63:0]     in_a, in_b;
  logic [30:0]     in_pc, in_pred_tgt;
  logic [11:0]     in_brimm;
  logic [TAGW-1:0] in_tag;
  logic            out_valid, flush_upper;
  logic [63:0]     out_result;
  logic [TAGW-1:0] out_tag;
  logic [30:0]     flush_path;
  logic [CNTW-1:0] misp_cnt;

  typedef struct {
    logic [3:0]  op;
    logic        word;
    logic [2:0]  br;
    logic        rvc;
    logic [63:0] a;
    logic [63:0] b;
    logic [30:0] pc;
    logic [11:0] brimm;
    logic        pred_t;
    logic [30:0] pred_tgt;
    logic [63:0] expv;
  } vec_t;

  typedef struct {
    logic [63:0]     res;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  vec_t alu_tab[16];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  exu_alu_pipe #(.XLEN(64), .PIPE(2), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_word(in_word), .in_br(in_br),
    .in_rvc(in_rvc), .in_a(in_a), .in_b(in_b), .in_pc(in_pc),
    .in_brimm(in_brimm), .in_pred_t(in_pred_t), .in_pred_tgt(in_pred_tgt),
    .in_tag(in_tag), .out_valid(out_valid), .out_result(out_result),
    .out_tag(out_tag), .flush_upper(flush_upper), .flush_path(flush_path),
    .misp_cnt(misp_cnt)
  );

  function automatic vec_t mk_br(input logic [3:0] op, input logic [2:0] br,
                                 input logic rvc, input logic [63:0] a, input logic [63:0] b,
                                 input logic [30:0] pc, input logic [11:0] brimm,
                                 input logic pred_t, input logic [30:0] pred_tgt,
                                 input logic [63:0] expv);
    vec_t v;
    v.op = op; v.word = 1'b0; v.br = br; v.rvc = rvc; v.a = a; v.b = b;
    v.pc = pc; v.brimm = brimm; v.pred_t = pred_t; v.pred_tgt = pred_tgt;
    v.expv = expv;
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic word,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] expv);
    vec_t v;
    v = mk_br(op, 3'd0, 1'b0, a, b, 31'd0, 12'd0, 1'b0, 31'd0, expv);
    v.word = word;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input logic [TAGW-1:0] tag, input bit expect_out);
    in_valid = 1'b1; in_op = v.op; in_word = v.word; in_br = v.br; in_rvc = v.rvc;
    in_a = v.a; in_b = v.b; in_pc = v.pc; in_brimm = v.brimm;
    in_pred_t = v.pred_t; in_pred_tgt = v.pred_tgt; in_tag = tag;
    if (expect_out) sb.push_back('{v.expv, tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_output("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic misp_step(input vec_t v, input logic [TAGW-1:0] tag, input logic [30:0] path);
    apply_stimulus(v, tag, 1'b1);
    check_output("misp flush_upper", 64'(flush_upper), 64'd1);
    check_output("misp flush_path", 64'(flush_path), 64'(path));
    exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
    @(posedge clk); #1;
    check_output("misp pulse end", 64'(flush_upper), 64'd0);
    check_output("misp_cnt", 64'(misp_cnt), 64'(exp_cnt));
  endtask

  // Writeback consumes an output on a cycle with out_valid and no freeze.
  always @(negedge clk) begin
    exp_t e;
    if (rst_l === 1'b1 && out_valid === 1'b1 && freeze === 1'b0) begin
      if (sb.size() == 0) begin
        check_output("spurious out_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_output("result", out_result, e.res);
        check_output("tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    alu_tab[0]  = mk(OP_ADD,   1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    alu_tab[1]  = mk(OP_MINU,  1'b0, ONES, 64'd5, 64'd5);
    alu_tab[2]  = mk(OP_MIN,   1'b0, ONES, 64'd5, ONES);
    alu_tab[3]  = mk(OP_SRA,   1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
    alu_tab[4]  = mk(OP_SUB,   1'b0, 64'd0, 64'd1, ONES);
    alu_tab[5]  = mk(OP_SLL,   1'b0, 64'd1, 64'h41, 64'd2);
    alu_tab[6]  = mk(OP_SRL,   1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
    alu_tab[7]  = mk(OP_SRL,   1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000);
    alu_tab[8]  = mk(OP_SLT,   1'b0, ONES, 64'd0, 64'd1);
    alu_tab[9]  = mk(OP_SLTU,  1'b0, ONES, 64'd0, 64'd0);
    alu_tab[10] = mk(OP_MAX,   1'b0, ONES, 64'd5, 64'd5);
    alu_tab[11] = mk(OP_MAXU,  1'b0, ONES, 64'd5, ONES);
    alu_tab[12] = mk(OP_XOR,   1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0);
    alu_tab[13] = mk(OP_PASSB, 1'b0, 64'd1, 64'h1234, 64'h1234);
    alu_tab[14] = mk(OP_SLTU,  1'b1, 64'h1_0000_0000, 64'hFFFF_FFFF_0000_0001, 64'd1);
    alu_tab[15] = mk(OP_SLL,   1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);

    rst_l = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_word = 1'b0; in_br = '0; in_rvc = 1'b0; in_a = '0; in_b = '0; in_pc = '0;
    in_brimm = '0; in_pred_t = 1'b0; in_pred_tgt = '0; in_tag = '0;
    #12;
    check_output("reset out_valid", 64'(out_valid), 64'd0);
    check_output("reset out_result", out_result, 64'd0);
    check_output("reset out_tag", 64'(out_tag), 64'd0);
    check_output("reset flush_upper", 64'(flush_upper), 64'd0);
    check_output("reset flush_path", 64'(flush_path), 64'd0);
    check_output("reset misp_cnt", 64'(misp_cnt), 64'd0);
    @(negedge clk) rst_l = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) apply_stimulus(alu_tab[i], TAGW'(i), 1'b1);
    wait_drain();

    // BEQ taken but predicted not-taken; the op right behind it must be dropped.
    apply_stimulus(mk_br(OP_ADD, BR_BEQ, 1'b0, 64'd7, 64'd7, 31'h80, 12'h8, 1'b0, 31'd0, 64'd14),
                   5'd24, 1'b1);
    check_output("beq flush_upper", 64'(flush_upper), 64'd1);
    check_output("beq flush_path", 64'(flush_path), 64'h88);
    apply_stimulus(mk(OP_ADD, 1'b0, 64'd1, 64'd1, 64'd2), 5'd30, 1'b0);
    exp_cnt = 1;
    check_output("beq pulse end", 64'(flush_upper), 64'd0);
    check_output("beq misp_cnt", 64'(misp_cnt), 64'd1);
    @(posedge clk); #1;
    check_output("self-kill out_valid", 64'(out_valid), 64'd0);
    wait_drain();

    apply_stimulus(mk_br(OP_LINK, BR_JAL, 1'b1, 64'h1000, 64'h20, 31'h200, 12'd0, 1'b1, 31'h810,
                         64'h402), 5'd25, 1'b1);
    check_output("jal good flush_upper", 64'(flush_upper), 64'd0);
    @(posedge clk); #1;
    misp_step(mk_br(OP_LINK, BR_JAL, 1'b1, 64'h1000, 64'h20, 31'h200, 12'd0, 1'b1, 31'h7FF,
                    64'h402), 5'd26, 31'h810);
    for (int i = 0; i < 3; i++) begin
      misp_step(mk_br(OP_PASSB, BR_BNE, 1'b0, 64'd3, 64'd3, 31'(32'h300 + i), 12'h4, 1'b1,
                      31'd0, 64'd3), 5'(27 + i), 31'(32'h302 + i));
    end
    wait_drain();

    // Freeze with two ops in flight, then flush the third.
    apply_stimulus(mk(OP_ADD, 1'b0, 64'd1, 64'd2, 64'd3), 5'd20, 1'b1);
    apply_stimulus(mk(OP_SUB, 1'b0, 64'd10, 64'd3, 64'd7), 5'd21, 1'b1);
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_output("freeze out_valid", 64'(out_valid), 64'd1);
      check_output("freeze out_result", out_result, 64'd3);
      check_output("freeze out_tag", 64'(out_tag), 64'd20);
    end
    freeze = 1'b0;
    apply_stimulus(mk(OP_OR, 1'b0, 64'd8, 64'd1, 64'd9), 5'd22, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      check_output("post-flush out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end

    apply_stimulus(mk(OP_ADD, 1'b0, 64'd5, 64'd6, 64'd11), 5'd9, 1'b1);
    rst_l = 1'b0;
    #1;
    check_output("async reset out_valid", 64'(out_valid), 64'd0);
    check_output("async reset out_result", out_result, 64'd0);
    check_output("async reset out_tag", 64'(out_tag), 64'd0);
    check_output("async reset flush_path", 64'(flush_path), 64'd0);
    check_output("async reset misp_cnt", 64'(misp_cnt), 64'd0);
    sb.delete();
    @(negedge clk) rst_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("after reset out_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exu_alu_pipe.md
Name: exu_alu_pipe

Overview:
- Parametrised, pipelined integer ALU and branch-resolution unit; next generation of the single-stage EXU ALU.
- Generalised in XLEN (32/64), pipeline depth (1 or 2 result stages) and compressed-instruction link/fallthrough.
- Adds MIN/MAX ops, 32-bit word ops on XLEN=64, self-kill of younger in-flight ops on mispredict, and a saturating mispredict counter.
- Sits in EXU beside mul/div; result feeds writeback, flush feeds IFU NPC.

Parameters:
XLEN, 64, datapath width; legal 32 or 64
PIPE, 2, result latency in cycles; legal 1 or 2
TAGW, 5, width of pass-through destination tag
CNTW, 16, mispredict counter width

Ports:
clk  in  1  top clock
rst_l  in  1  asynchronous active-low reset
freeze  in  1  global stall; holds every stage
flush  in  1  external kill of all in-flight and incoming ops
in_valid  in  1  issue valid
in_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 MIN,11 MAX,12 MINU,13 MAXU,14 PASSB,15 LINK
in_word  in  1  32-bit op, result sign-extended (ignored when XLEN=32)
in_br  in  3  0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 JAL
in_rvc  in  1  compressed instruction (link/fallthrough +2 instead of +4)
in_a  in  XLEN  operand A
in_b  in  XLEN  operand B / immediate
in_pc  in  31  pc[31:1]
in_brimm  in  12  branch offset [12:1]
in_pred_t  in  1  predicted taken
in_pred_tgt  in  31  predicted target [31:1]
in_tag  in  TAGW  destination tag
out_valid  out  1  result valid
out_result  out  XLEN  result
out_tag  out  TAGW  tag of result
flush_upper  out  1  mispredict flush pulse
flush_path  out  31  redirect pc[31:1]
misp_cnt  out  CNTW  saturating mispredict count

Behaviour:
- Reset: all stage valids 0, out_valid 0, out_result 0, out_tag 0, flush_upper 0, flush_path 0, misp_cnt 0.
- Stage E1: captures inputs when in_valid & ~freeze; E1 valid <= in_valid & ~flush & ~self_kill. freeze holds all stage registers and valids; outputs keep last values, flush_upper forced 0 while freeze.
- Compute in E1 (combinational from E1 regs). PIPE=1: out_* driven from E1. PIPE=2: E2 registers result/tag/valid, out_* from E2. Latency exactly PIPE cycles after accepted issue.
- Arithmetic: ADD/SUB modulo 2^XLEN. Word mode: operands use bits [31:0], shift amount b[4:0], result sign-extended from bit 31; compares in word mode use sign/zero of low 32 bits. Non-word shift amount b[log2(XLEN)-1:0]. SLT/SLTU result 0 or 1. MIN/MAX signed, MINU/MAXU unsigned; equal operands return A. PASSB returns B. LINK returns {pc+(rvc?2:4), 0} zero-extended.
- Branch, resolved in E1: taken = condition (BEQ/BNE/BLT/BGE/BLTU/BGEU on full-width or word operands), always for JAL. target = pc + sext(brimm), for JAL target = (A+B)[31:1]. fallthrough = pc + (rvc?1:2) in [31:1] units.
- misp = valid & (br!=0) & ((taken!=pred_t) | (JAL & pred_tgt!=target)).
- flush_upper = misp & ~flush & ~freeze, single-cycle pulse in E1 cycle regardless of PIPE. flush_path = taken ? target : fallthrough; holds last value otherwise.
- self_kill: on flush_upper, op issuing that same cycle is dropped (E1 valid <= 0). Mispredicting op itself completes (writes link result).
- External flush kills E1 and E2 valids at next edge; out_valid drops next cycle; flush has priority over freeze for valids.
- misp_cnt increments by 1 on each flush_upper; saturates at all-ones, never wraps.
- Pc adders wrap mod 2^32.

Test Plan:
- XLEN=64,PIPE=2: ADD a=0x7FFF_FFFF, b=1, word=1 -> out_result 0xFFFF_FFFF_8000_0000 two cycles later, tag echoed.
- MINU a=0xFFFF...FFFF, b=5 -> 5; MIN same -> 0xFFFF...FFFF; SRA word a=0x8000_0000, b=4 -> 0xFFFF_FFFF_F800_0000.
- BEQ a=b, pred_t=0, pc=0x100>>1, brimm=0x10>>1 -> flush_upper 1 one cycle, flush_path=0x110>>1, misp_cnt=1; op issued same cycle never produces out_valid.
- JAL rvc=1, pred_t=1, pred_tgt equal to A+B -> no flush, out_result=pc+2; pred_tgt differing -> flush, path=A+B.
- Issue 3 back-to-back ops, assert freeze 2 cycles mid-stream, then flush -> outputs frozen during freeze, no out_valid after flush edge.
- CNTW=2: 5 mispredicts -> misp_cnt 1,2,3,3,3; assert rst_l low mid-stream -> all outputs 0 immediately.
